// File: rtl/divisor_4b_pkg.sv
// divisor_4b_pkg: shared width constant and FSM state encoding for the button divider.
// Rev 1.0
`default_nettype none

package divisor_4b_pkg;

  localparam int W = 4;

  localparam logic [2:0] LOAD_NUM  = 3'd0;
  localparam logic [2:0] LOAD_DEN  = 3'd1;
  localparam logic [2:0] CALC      = 3'd2;
  localparam logic [2:0] SHOW_QUOT = 3'd3;
  localparam logic [2:0] SHOW_REM  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/divisor_4b_div_core.sv
// div_core: W-cycle unsigned restoring divider, one quotient bit per cycle, MSB first.
// Rev 1.0
`default_nettype none

module div_core #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W + 1);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem;
  logic [W-1:0]  dq;
  logic [W-1:0]  dvs;

  logic [W:0]    trial;
  logic [W:0]    diff;
  logic          qbit;
  logic [W-1:0]  rem_next;
  logic [W-1:0]  dq_next;

  // dq starts as the dividend; quotient bits shift in as dividend bits shift out
  always_comb begin
    trial    = {rem, dq[W-1]};
    diff     = trial - {1'b0, dvs};
    qbit     = (trial >= {1'b0, dvs});
    rem_next = qbit ? diff[W-1:0] : trial[W-1:0];
    dq_next  = {dq[W-2:0], qbit};
  end

  // Results are the outcome of the step taking place this cycle; valid while done is high
  assign done      = busy && (cnt == CW'(1));
  assign quotient  = dq_next;
  assign remainder = rem_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      dq   <= '0;
      dvs  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CW'(W);
      rem  <= '0;
      dq   <= dividend;
      dvs  <= divisor;
    end else if (busy) begin
      rem  <= rem_next;
      dq   <= dq_next;
      cnt  <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/divisor_4b.sv
// divisor_4b: button-driven divider front end (edge detect, FSM, operand registers, display).
// Rev 1.0
`default_nettype none

module divisor_4b #(
  parameter int W = divisor_4b_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up,
  input  logic         down,
  input  logic         ok,
  output logic [W-1:0] leds
);

  import divisor_4b_pkg::*;

  logic         up_q, down_q, ok_q;
  logic         up_e, down_e, ok_e, inc, dec;
  logic [2:0]   state, state_n;
  logic [W-1:0] num, num_n, den, den_n, quot, quot_n, rem, rem_n, leds_n;
  logic         start, done;
  logic [W-1:0] core_q, core_r;

  function automatic logic [W-1:0] edit(input logic [W-1:0] v, input logic i, input logic d);
    if (i)      return v + W'(1);
    else if (d) return v - W'(1);
    else        return v;
  endfunction

  assign up_e   = up & ~up_q;
  assign down_e = down & ~down_q;
  assign ok_e   = ok & ~ok_q;
  // Simultaneous up and down presses cancel out
  assign inc    = up_e & ~down_e;
  assign dec    = down_e & ~up_e;

  always_comb begin
    state_n = state;
    num_n   = num;
    den_n   = den;
    quot_n  = quot;
    rem_n   = rem;
    start   = 1'b0;
    case (state)
      LOAD_NUM: begin
        num_n = edit(num, inc, dec);
        if (ok_e) begin
          state_n = LOAD_DEN;
          den_n   = '0;
        end
      end
      LOAD_DEN: begin
        den_n = edit(den, inc, dec);
        if (ok_e) begin
          state_n = CALC;
          start   = 1'b1;
        end
      end
      CALC: begin
        if (done) begin
          quot_n  = core_q;
          rem_n   = core_r;
          state_n = SHOW_QUOT;
        end
      end
      SHOW_QUOT: if (ok_e) state_n = SHOW_REM;
      SHOW_REM: begin
        if (ok_e) begin
          state_n = LOAD_NUM;
          num_n   = '0;
          den_n   = '0;
          quot_n  = '0;
          rem_n   = '0;
        end
      end
      default: state_n = LOAD_NUM;
    endcase
  end

  // leds follow the next-state selection so they change on the same edge as the shown register
  always_comb begin
    leds_n = '0;
    case (state_n)
      LOAD_NUM:       leds_n = num_n;
      LOAD_DEN, CALC: leds_n = den_n;
      SHOW_QUOT:      leds_n = quot_n;
      SHOW_REM:       leds_n = rem_n;
      default:        leds_n = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      ok_q   <= 1'b0;
      state  <= LOAD_NUM;
      num    <= '0;
      den    <= '0;
      quot   <= '0;
      rem    <= '0;
      leds   <= '0;
    end else begin
      up_q   <= up;
      down_q <= down;
      ok_q   <= ok;
      state  <= state_n;
      num    <= num_n;
      den    <= den_n;
      quot   <= quot_n;
      rem    <= rem_n;
      leds   <= leds_n;
    end
  end

  div_core #(.W(W)) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (num),
    .divisor   (den_n),
    .done      (done),
    .quotient  (core_q),
    .remainder (core_r)
  );

endmodule

`default_nettype wire

// File: tb/tb_divisor_4b.sv
// tb_divisor_4b: self-checking bench for divisor_4b (vector table plus scoreboard queue).
// Rev 1.0
`default_nettype none

module tb_divisor_4b;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, up, down, ok;
  logic [W-1:0] leds;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  divisor_4b #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .up   (up),
    .down (down),
    .ok   (ok),
    .leds (leds)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: leds=%0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_pop(input string name);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, leds=%0d", name, leds);
    end else begin
      check(name, leds, exp_q.pop_front());
    end
  endtask

  task automatic press_up();
    up = 1'b1; tick(); up = 1'b0; tick();
  endtask

  task automatic press_down();
    down = 1'b1; tick(); down = 1'b0; tick();
  endtask

  task automatic press_ok();
    ok = 1'b1; tick(); ok = 1'b0; tick();
  endtask

  // From LOAD_NUM with num=0: load operands and enter CALC (returns one edge into CALC)
  task automatic enter_calc(input logic [W-1:0] n, input logic [W-1:0] d,
                            input logic [W-1:0] q, input logic [W-1:0] r);
    for (int i = 0; i < int'(n); i++) press_up();
    check("num_loaded", leds, n);
    press_ok();
    check("den_cleared", leds, 4'd0);
    for (int i = 0; i < int'(d); i++) press_up();
    check("den_loaded", leds, d);
    exp_q.push_back(q);
    exp_q.push_back(r);
    press_ok();
  endtask

  task automatic finish_div(input logic [W-1:0] d);
    check("calc_shows_den", leds, d);
    tick();
    check_pop("quotient");
    press_ok();
    check_pop("remainder");
    press_ok();
    check("back_to_load_num", leds, 4'd0);
  endtask

  initial begin
    vecs[0] = '{4'd13, 4'd4,  4'd3,  4'd1};
    vecs[1] = '{4'd7,  4'd0,  4'd15, 4'd7};
    vecs[2] = '{4'd4,  4'd4,  4'd1,  4'd0};
    vecs[3] = '{4'd15, 4'd1,  4'd15, 4'd0};
    vecs[4] = '{4'd15, 4'd2,  4'd7,  4'd1};
    vecs[5] = '{4'd0,  4'd5,  4'd0,  4'd0};
    vecs[6] = '{4'd9,  4'd15, 4'd0,  4'd9};
    vecs[7] = '{4'd14, 4'd3,  4'd4,  4'd2};

    rst = 1'b1; up = 1'b0; down = 1'b0; ok = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_leds", leds, 4'd0);

    // Four ups, ok, then den 5 up / 1 down = 4; 4/4 = 1 rem 0
    repeat (4) press_up();
    check("num_four", leds, 4'd4);
    press_ok();
    check("load_den_zero", leds, 4'd0);
    repeat (5) press_up();
    press_down();
    check("den_four", leds, 4'd4);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd0);
    press_ok();
    repeat (W - 2) tick();
    finish_div(4'd4);

    // Wrap both ways
    press_down();
    check("wrap_down", leds, 4'd15);
    press_up();
    check("wrap_up", leds, 4'd0);

    // Long hold counts once
    up = 1'b1;
    repeat (10) tick();
    up = 1'b0;
    tick();
    check("hold_once", leds, 4'd1);

    // Simultaneous press cancels
    up = 1'b1; down = 1'b1; tick();
    up = 1'b0; down = 1'b0; tick();
    check("up_down_cancel", leds, 4'd1);
    press_down();
    check("back_to_zero", leds, 4'd0);

    // Button already high when reset releases counts as a press
    rst = 1'b1; up = 1'b1; tick();
    rst = 1'b0; tick();
    up = 1'b0; tick();
    check("first_cycle_press", leds, 4'd1);
    press_down();
    check("first_cycle_undo", leds, 4'd0);

    for (int i = 0; i < 8; i++) begin
      enter_calc(vecs[i].num, vecs[i].den, vecs[i].quot, vecs[i].rem);
      repeat (W - 2) tick();
      finish_div(vecs[i].den);
    end

    // ok pressed during CALC is ignored
    enter_calc(4'd13, 4'd4, 4'd3, 4'd1);
    ok = 1'b1; tick();
    ok = 1'b0;
    repeat (W - 3) tick();
    finish_div(4'd4);

    // Reset in the middle of CALC
    enter_calc(4'd7, 4'd2, 4'd3, 4'd1);
    rst = 1'b1; tick();
    rst = 1'b0;
    check("rst_in_calc", leds, 4'd0);
    exp_q.delete();
    repeat (W + 2) tick();
    check("no_stale_result", leds, 4'd0);
    press_up();
    check("num_cleared_by_rst", leds, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
